// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// controller states and the byte-enable helper.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    // Lanes touched by an access of the given size at byte offset off.
    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B, F3_BU: byte_en = 4'b0001 << off;
            F3_H, F3_HU: byte_en = 4'b0011 << off;
            F3_W:        byte_en = 4'b1111;
            default:     byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_sync_if.sv
// Request/response bus between the MEM stage and the data memory.
interface dmem_lsu_sync_if #(
    parameter int unsigned ADDR_W = 11
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/dmem_lsu_sync_lsu_align.sv
// Combinational alignment logic: store lane replication and byte enables,
// load lane selection with sign/zero extension, and fault decode.
module lsu_align
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rword,
    output logic [31:0]       st_data,
    output logic [3:0]        st_be,
    output logic [31:0]       ld_data,
    output logic              fault
);

    logic [ADDR_W-3:0] widx;
    logic [1:0]        off;
    logic              oob;
    logic              misalign;
    logic              illegal;
    logic [7:0]        lb;
    logic [15:0]       lh;

    // Decode faults, build store lanes and extend the selected load lanes.
    always_comb begin
        widx = addr[ADDR_W-1:2];
        off  = addr[1:0];
        oob  = 32'(widx) >= DEPTH_WORDS;

        misalign = 1'b0;
        case (funct3)
            F3_H, F3_HU: misalign = off[0];
            F3_W:        misalign = (off != 2'b00);
            default:     misalign = 1'b0;
        endcase

        if (we) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end

        fault = oob | misalign | illegal;

        case (funct3)
            F3_B:    st_data = {4{wdata[7:0]}};
            F3_H:    st_data = {2{wdata[15:0]}};
            default: st_data = wdata;
        endcase
        st_be = (we && !fault) ? byte_en(funct3, off) : 4'b0000;

        case (off)
            2'd0:    lb = rword[7:0];
            2'd1:    lb = rword[15:8];
            2'd2:    lb = rword[23:16];
            default: lb = rword[31:24];
        endcase
        lh = off[1] ? rword[31:16] : rword[15:0];

        case (funct3)
            F3_B:    ld_data = {{24{lb[7]}}, lb};
            F3_BU:   ld_data = {24'h0, lb};
            F3_H:    ld_data = {{16{lh[15]}}, lh};
            F3_HU:   ld_data = {16'h0, lh};
            F3_W:    ld_data = rword;
            default: ld_data = '0;
        endcase
        if (fault || we) begin
            ld_data = '0;
        end
    end

endmodule

// File: rtl/dmem_lsu_sync.sv
// Byte-addressable data memory with load/store unit, reset-time clear sweep,
// registered single-cycle responses and a synchronous debug read port.
module dmem_lsu_sync
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 512,
    parameter int unsigned ADDR_W         = 11,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_lsu_sync_if.slave    bus,
    input  logic [ADDR_W-3:0] dbg_addr,
    output logic [31:0]       dbg_rdata,
    output logic              init_busy
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [3:0][7:0]  mem [DEPTH_WORDS];
    state_t           state;
    logic [IDX_W-1:0] clr_cnt;

    logic             accept;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      rword;
    logic [31:0]      st_data;
    logic [3:0]       st_be;
    logic [31:0]      ld_data;
    logic             fault;

    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    // Handshake and array read for the addressed word (out-of-range reads are masked by fault).
    always_comb begin
        accept  = bus.req_valid & bus.req_ready;
        acc_idx = bus.req_addr[IDX_W+1:2];
        rword   = mem[acc_idx];
    end

    lsu_align #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_align (
        .we     (bus.req_we),
        .funct3 (bus.req_funct3),
        .addr   (bus.req_addr),
        .wdata  (bus.req_wdata),
        .rword  (rword),
        .st_data(st_data),
        .st_be  (st_be),
        .ld_data(ld_data),
        .fault  (fault)
    );

    // Single write port shared by the clear sweep and accepted stores.
    always_comb begin
        wr_idx  = acc_idx;
        wr_be   = '0;
        wr_data = st_data;
        if (state == ST_INIT) begin
            wr_idx  = clr_cnt;
            wr_be   = '1;
            wr_data = '0;
        end else if (accept) begin
            wr_be = st_be;
        end
    end

    // Byte-lane writes into the array.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < 4; l++) begin
            if (wr_be[l]) begin
                mem[wr_idx][l] <= wr_data[8*l +: 8];
            end
        end
    end

    // Controller FSM: clear sweep, ready flag and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
            clr_cnt       <= '0;
            init_busy     <= CLEAR_ON_RESET;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= accept;
            bus.rsp_fault <= accept & fault;
            bus.rsp_rdata <= accept ? ld_data : '0;
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + IDX_W'(1);
                    if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        state         <= ST_READY;
                        clr_cnt       <= '0;
                        init_busy     <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    init_busy     <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Debug read: read-first against a same-edge store, zero beyond the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata <= '0;
        end else if (32'(dbg_addr) < DEPTH_WORDS) begin
            dbg_rdata <= mem[dbg_addr[IDX_W-1:0]];
        end else begin
            dbg_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_sync.sv
// Directed bench for dmem_lsu_sync: clear sweep timing, load/store extension,
// faults, back-to-back store/load against a word model, and mid-flight reset.
module tb_dmem_lsu_sync;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 12;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-3:0] dbg_addr;
    logic [31:0]   dbg_rdata;
    logic          init_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [2:0]  f3_tab [5];
    logic [33:0] exp_rsp;
    logic [31:0] exp_dbg;
    int unsigned rw;
    int unsigned roff;
    logic [2:0]  rf3;
    logic        rwe;
    logic [31:0] rwd;
    logic [31:0] rcur;
    logic [31:0] rres;
    logic [7:0]  rb;
    logic [15:0] rh;

    dmem_lsu_sync_if #(.ADDR_W(AW)) bus ();

    dmem_lsu_sync #(
        .DEPTH_WORDS   (DEPTH),
        .ADDR_W        (AW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_rdata(dbg_rdata),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
    endtask

    // Starts and ends on a falling edge; one request, response checked one cycle later.
    task automatic req(input string tag, input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic flt, input logic [31:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(negedge clk);
        drive_idle();
        chk(tag, {bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata}, {1'b1, flt, rd});
        @(negedge clk);
        chk({tag, "_single"}, bus.rsp_valid, 1'b0);
    endtask

    task automatic dbg(input string tag, input int unsigned idx, input logic [31:0] exp);
        dbg_addr = (AW-2)'(idx);
        @(negedge clk);
        chk(tag, dbg_rdata, exp);
    endtask

    // Called on the first falling edge after reset release; counts busy cycles.
    task automatic wait_init(input string tag);
        int n = 0;
        bit rdy_seen = 1'b0;
        bit vld_seen = 1'b0;
        for (int i = 0; i < 2000 && init_busy; i++) begin
            n++;
            if (bus.req_ready) rdy_seen = 1'b1;
            if (bus.rsp_valid) vld_seen = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, 512);
        chk({tag, "_ready_in_init"}, rdy_seen, 1'b0);
        chk({tag, "_rsp_in_init"}, vld_seen, 1'b0);
        chk({tag, "_ready_after"}, bus.req_ready, 1'b1);
    endtask

    initial begin
        f3_tab = '{B, H, W, BU, HU};
        drive_idle();
        dbg_addr = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_valid", bus.rsp_valid, 1'b0);
        chk("rst_fault", bus.rsp_fault, 1'b0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_dbg", dbg_rdata, 32'h0);
        chk("rst_busy", init_busy, 1'b1);

        rst_n = 1'b1;
        wait_init("init1");
        dbg("dbg_w0_init", 0, 32'h0);
        dbg("dbg_w511_init", 511, 32'h0);

        // Extension of a stored word
        req("sw_10",  1'b1, W,  12'h010, 32'h8000_00F1, 1'b0, 32'h0);
        req("lb_10",  1'b0, B,  12'h010, 32'h0, 1'b0, 32'hFFFF_FFF1);
        req("lbu_10", 1'b0, BU, 12'h010, 32'h0, 1'b0, 32'h0000_00F1);
        req("lh_10",  1'b0, H,  12'h010, 32'h0, 1'b0, 32'h0000_00F1);
        req("lhu_10", 1'b0, HU, 12'h010, 32'h0, 1'b0, 32'h0000_00F1);

        // Partial stores
        req("sw0_10", 1'b1, W,  12'h010, 32'h0, 1'b0, 32'h0);
        req("sb_13",  1'b1, B,  12'h013, 32'h0000_00AA, 1'b0, 32'h0);
        req("lw_sb",  1'b0, W,  12'h010, 32'h0, 1'b0, 32'hAA00_0000);
        req("sh_12",  1'b1, H,  12'h012, 32'h0000_8001, 1'b0, 32'h0);
        req("lh_12",  1'b0, H,  12'h012, 32'h0, 1'b0, 32'hFFFF_8001);
        req("lhu_12", 1'b0, HU, 12'h012, 32'h0, 1'b0, 32'h0000_8001);
        req("lw_sh",  1'b0, W,  12'h010, 32'h0, 1'b0, 32'h8001_0000);
        req("lbu_13", 1'b0, BU, 12'h013, 32'h0, 1'b0, 32'h0000_0080);
        req("lb_12",  1'b0, B,  12'h012, 32'h0, 1'b0, 32'h0000_0001);

        // Faults: no write, zero data
        req("f_lh_11",  1'b0, H,      12'h011, 32'h0, 1'b1, 32'h0);
        req("f_sw_16",  1'b1, W,      12'h016, 32'hDEAD_BEEF, 1'b1, 32'h0);
        req("f_lw_800", 1'b0, W,      12'h800, 32'h0, 1'b1, 32'h0);
        req("f_sb_f4",  1'b1, 3'b100, 12'h010, 32'h0000_0055, 1'b1, 32'h0);
        req("f_ld_f3",  1'b0, 3'b011, 12'h010, 32'h0, 1'b1, 32'h0);
        req("f_sw_ffc", 1'b1, W,      12'hFFC, 32'h1111_1111, 1'b1, 32'h0);
        req("f_sh_13",  1'b1, H,      12'h013, 32'h0000_FFFF, 1'b1, 32'h0);
        dbg("f_dbg_w4", 4, 32'h8001_0000);
        dbg("f_dbg_w5", 5, 32'h0);
        dbg("f_dbg_w511", 511, 32'h0);

        // Array ends and debug range
        req("sw_0",   1'b1, W, 12'h000, 32'h1234_5678, 1'b0, 32'h0);
        dbg("dbg_w0", 0, 32'h1234_5678);
        dbg("dbg_oob", 512, 32'h0);
        req("sw_7fc", 1'b1, W, 12'h7FC, 32'hCAFE_F00D, 1'b0, 32'h0);
        req("lw_7fc", 1'b0, W, 12'h7FC, 32'h0, 1'b0, 32'hCAFE_F00D);
        dbg("dbg_w511", 511, 32'hCAFE_F00D);

        // Back-to-back store/load pairs on words 64..67; debug follows the same word
        for (int w = 64; w < 68; w++) ref_mem[w] = 32'h0;
        rw = 64;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                chk("b2b_rsp", {bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata}, exp_rsp);
                chk("b2b_dbg", dbg_rdata, exp_dbg);
            end
            rwe = (i % 2 == 0);
            if (rwe) rw = $urandom_range(67, 64);
            rf3 = f3_tab[rwe ? $urandom_range(2, 0) : $urandom_range(4, 0)];
            case (rf3)
                B, BU:   roff = $urandom_range(3, 0);
                H, HU:   roff = 2 * $urandom_range(1, 0);
                default: roff = 0;
            endcase
            rwd  = $urandom();
            rcur = ref_mem[rw];
            exp_dbg = rcur;
            rb = rcur[8*roff +: 8];
            rh = rcur[8*roff +: 16];
            if (rwe) begin
                rres = rcur;
                case (rf3)
                    B:       rres[8*roff +: 8]  = rwd[7:0];
                    H:       rres[8*roff +: 16] = rwd[15:0];
                    default: rres = rwd;
                endcase
                ref_mem[rw] = rres;
                exp_rsp = {2'b10, 32'h0};
            end else begin
                case (rf3)
                    B:       exp_rsp = {2'b10, {24{rb[7]}}, rb};
                    BU:      exp_rsp = {2'b10, 24'h0, rb};
                    H:       exp_rsp = {2'b10, {16{rh[15]}}, rh};
                    HU:      exp_rsp = {2'b10, 16'h0, rh};
                    default: exp_rsp = {2'b10, rcur};
                endcase
            end
            bus.req_valid  = 1'b1;
            bus.req_we     = rwe;
            bus.req_funct3 = rf3;
            bus.req_addr   = AW'(rw * 4 + roff);
            bus.req_wdata  = rwd;
            dbg_addr       = (AW-2)'(rw);
            @(negedge clk);
        end
        drive_idle();
        chk("b2b_rsp_last", {bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata}, exp_rsp);
        chk("b2b_dbg_last", dbg_rdata, exp_dbg);
        @(negedge clk);
        chk("b2b_idle", bus.rsp_valid, 1'b0);

        // Reset while a load response is in flight
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = W;
        bus.req_addr   = 12'h010;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        chk("midrst_valid", bus.rsp_valid, 1'b0);
        chk("midrst_rdata", bus.rsp_rdata, 32'h0);
        chk("midrst_busy", init_busy, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        wait_init("init2");
        dbg("clr_dbg_w4", 4, 32'h0);
        dbg("clr_dbg_w0", 0, 32'h0);
        dbg("clr_dbg_w511", 511, 32'h0);
        dbg("clr_dbg_w64", 64, 32'h0);
        req("clr_lw_10", 1'b0, W, 12'h010, 32'h0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
